instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the pipelined MIPS core, directly upstream of the combinational-read instruction memory. It owns the program counter and drives the memory's 32-bit byte address, with the memory indexing words by bits [10:2]. It captures the returned instruction into the IF/ID pipeline register. It also handles stall, flush, branch/jump redirect and a halt instruction.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch.

- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset. One clock domain only.
- Stall  in  1  hold PC and IF/ID contents.
- Flush  in  1  turn the next IF/ID capture into a bubble.
- Redirect  in  1  load PC from RedirectTarget.
- RedirectTarget  in  32  branch/jump target byte address.
- ImemAddress  out  32  address to instruction memory; equals PC combinationally.
- ImemInstruction  in  32  instruction word returned combinationally by memory.
- PC  out  32  current program counter.
- IFID_Instruction  out  32  latched instruction.
- IFID_PCPlus4  out  32  PC+4 of the latched instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction.
- Halted  out  1  fetch is halted.
- Misaligned  out  1  one-cycle pulse when a redirect target had bits [1:0] not equal to 0.
- FetchCount  out  32  number of valid instructions captured.

## Operation
- FSM states: BOOT, RUN, HALTED.
- **Reset:** state=BOOT, PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, Misaligned=0, FetchCount=0.
- **BOOT:**
  - Lasts one cycle.
  - Nothing is captured.
  - Moves to RUN.
  - If Redirect is high in BOOT, PC takes the target.
- **RUN, priority at each edge** (highest first):
  - Redirect: PC <= {RedirectTarget[31:2], 2'b00}. Misaligned <= |RedirectTarget[1:0]. IF/ID captures a bubble (Valid=0). Stall is ignored.
  - Flush: IFID_Valid <= 0. PC <= PC+4 unless Stall, in which case PC is held.
  - Stall: PC, IFID_Instruction, IFID_PCPlus4 and IFID_Valid are all held.
  - Otherwise: IFID_Instruction <= ImemInstruction, IFID_PCPlus4 <= PC+4, IFID_Valid <= 1, FetchCount += 1, PC <= PC+4.
- **Halt:** in the normal-capture case with ImemInstruction == HALT_WORD:
  - The word is captured as valid and counted.
  - PC does not advance.
  - State moves to HALTED and Halted <= 1.
- **HALTED:**
  - IFID_Valid <= 0 every cycle. PC is held.
  - Stall and Flush have no further effect.
  - Redirect loads PC, clears Halted and moves to RUN.
- **Arithmetic:**
  - PC+4 is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
  - FetchCount wraps at 2^32.
  - Bits [1:0] of PC are always 0.
- Misaligned is high only in the cycle immediately after the offending redirect.

## Timing
- ImemAddress follows PC with zero latency; the memory read is combinational in the same cycle.
- Capture latency is 1 edge: the word at PC appears on IFID_* after the next rising edge.
- The first valid IF/ID appears at the 2nd rising edge after Rst_n deasserts (BOOT, then RUN capture).
- After a redirect edge, the target's instruction appears on IFID one edge later. There is exactly one bubble.
- Rst_n asserted mid-operation clears all state immediately, without waiting for Clk, regardless of Stall, Redirect or HALTED.
- Stall held N cycles keeps IF/ID bit-identical for N cycles and FetchCount unchanged.

## Structure
- Shared package holds:
  - FSM state encodings (BOOT, RUN, HALTED).
  - The default HALT_WORD and NOP (32'h0) constants.
  - A PC increment constant of 4.
- One sub-module, `ifid_register`: holds Instruction, PCPlus4 and Valid, with hold (stall) and bubble (flush) controls.
- PC register, FSM and FetchCount live in the top module.

## Test plan
- **Reset then run:** memory word i = i*3, release Rst_n.
  - After the 2nd edge: IFID_Instruction=0, IFID_PCPlus4=4, Valid=1.
  - After the 3rd edge: IFID_Instruction=3, IFID_PCPlus4=8, FetchCount=2.
- **Stall:** at PC=0x10, hold Stall 3 cycles.
  - PC stays 0x10 and IF/ID is unchanged for 3 cycles.
  - After release, the next capture is word 4 (value 12).
- **Redirect with simultaneous Stall and Flush,** target 0x43:
  - PC becomes 0x40, Misaligned pulses once, one bubble appears.
  - The next capture is word 16 (value 48), with IFID_PCPlus4=0x44.
- **Halt:** put HALT_WORD at 0x20.
  - The word is captured valid and Halted=1.
  - PC stays 0x20 and Valid=0 thereafter.
  - Redirect to 0 resumes fetch at word 0.
- **Wrap:** redirect to 0xFFFF_FFFC. The next edge gives PC=0 and IFID_PCPlus4=0.
- **Async reset mid-run:** pulse Rst_n low between clock edges during a stall.
  - All outputs return to reset values immediately; PC=RESET_PC and state=BOOT.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] PC_INCR           = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface instruction_fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] pc;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, redirect, redirect_target, imem_instruction,
    output imem_address, pc, ifid_instruction, ifid_pcplus4, ifid_valid,
           halted, misaligned, fetch_count
  );

  modport slave (
    output stall, flush, redirect, redirect_target, imem_instruction,
    input  imem_address, pc, ifid_instruction, ifid_pcplus4, ifid_valid,
           halted, misaligned, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_stage_ifid_register.sv
// IF/ID pipeline register; bubble clears Valid only, capture loads all fields.
module ifid_register
  import instruction_fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        capture_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (bubble_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q   <= NOP_WORD;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, BOOT/RUN/HALTED sequencing, fetch counter and IF/ID capture.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input logic                        clk_i,
  input logic                        rst_n_i,
  instruction_fetch_stage_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         misaligned_q, misaligned_d;
  logic         ifid_capture, ifid_bubble;
  logic [31:0]  pc_plus4;
  logic         is_halt_word;

  assign pc_plus4     = pc_q + PC_INCR;
  assign is_halt_word = (bus.imem_instruction == HALT_WORD);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.redirect && !bus.flush && !bus.stall && is_halt_word)
          state_d = ST_HALTED;
      end
      ST_HALTED: if (bus.redirect) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Redirect wins in every state; Stall/Flush only matter while running.
  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    misaligned_d = 1'b0;
    ifid_capture = 1'b0;
    ifid_bubble  = 1'b0;
    if (bus.redirect) begin
      pc_d         = align_word(bus.redirect_target);
      misaligned_d = |bus.redirect_target[1:0];
    end
    unique case (state_q)
      ST_BOOT: ;
      ST_RUN: begin
        if (bus.redirect) begin
          ifid_bubble = 1'b1;
        end else if (bus.flush) begin
          ifid_bubble = 1'b1;
          if (!bus.stall) pc_d = pc_plus4;
        end else if (!bus.stall) begin
          ifid_capture = 1'b1;
          count_d      = count_q + 32'd1;
          if (!is_halt_word) pc_d = pc_plus4;
        end
      end
      ST_HALTED: ifid_bubble = 1'b1;
      default: ;
    endcase
  end

  ifid_register u_ifid (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .capture_i (ifid_capture),
    .bubble_i  (ifid_bubble),
    .instr_i   (bus.imem_instruction),
    .pcplus4_i (pc_plus4),
    .instr_o   (bus.ifid_instruction),
    .pcplus4_o (bus.ifid_pcplus4),
    .valid_o   (bus.ifid_valid)
  );

  assign bus.imem_address = pc_q;
  assign bus.pc           = pc_q;
  assign bus.halted       = (state_q == ST_HALTED);
  assign bus.misaligned   = misaligned_q;
  assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory word i holds i*3.
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic halt_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] word_idx;
  assign word_idx = {23'd0, bus.imem_address[10:2]};
  assign bus.imem_instruction =
    (halt_en && bus.imem_address == 32'h20) ? 32'hFFFF_FFFF : word_idx * 32'd3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
    bus.stall           = s;
    bus.flush           = f;
    bus.redirect        = r;
    bus.redirect_target = t;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
    check({tag, "_instr"}, bus.ifid_instruction, ins);
    check({tag, "_pcp4"}, bus.ifid_pcplus4, p4);
    check({tag, "_valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_addr", bus.imem_address, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_count", bus.fetch_count, 32'h0);
    check("rst_halted", {31'd0, bus.halted}, 32'h0);
    check("rst_mis", {31'd0, bus.misaligned}, 32'h0);
    rst_n_i = 1'b1;

    // reset then run
    tick();
    check("boot_pc", bus.pc, 32'h0);
    check("boot_valid", {31'd0, bus.ifid_valid}, 32'h0);
    tick();
    check_ifid("run1", 32'd0, 32'd4, 1'b1);
    check("run1_count", bus.fetch_count, 32'd1);
    tick();
    check_ifid("run2", 32'd3, 32'd8, 1'b1);
    check("run2_count", bus.fetch_count, 32'd2);
    tick();
    tick();
    check("pre_stall_pc", bus.pc, 32'h10);
    check_ifid("pre_stall", 32'd9, 32'h10, 1'b1);

    // stall three cycles
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc, 32'h10);
      check_ifid("stall", 32'd9, 32'h10, 1'b1);
      check("stall_count", bus.fetch_count, 32'd4);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("post_stall", 32'd12, 32'h14, 1'b1);
    check("post_stall_count", bus.fetch_count, 32'd5);

    // redirect with simultaneous stall and flush, misaligned target
    drive(1'b1, 1'b1, 1'b1, 32'h43);
    tick();
    check("redir_pc", bus.pc, 32'h40);
    check("redir_mis", {31'd0, bus.misaligned}, 32'd1);
    check("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("redir_count", bus.fetch_count, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("redir_next", 32'd48, 32'h44, 1'b1);
    check("redir_mis_clr", {31'd0, bus.misaligned}, 32'd0);
    check("redir_next_pc", bus.pc, 32'h44);

    // halt at 0x20
    halt_en = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    check("h_redir_pc", bus.pc, 32'h20);
    check("h_redir_mis", {31'd0, bus.misaligned}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("halt_cap", 32'hFFFF_FFFF, 32'h24, 1'b1);
    check("halt_flag", {31'd0, bus.halted}, 32'd1);
    check("halt_pc", bus.pc, 32'h20);
    check("halt_count", bus.fetch_count, 32'd7);
    tick();
    check("halted_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("halted_pc", bus.pc, 32'h20);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("halted_sf_pc", bus.pc, 32'h20);
    check("halted_sf_flag", {31'd0, bus.halted}, 32'd1);
    check("halted_sf_count", bus.fetch_count, 32'd7);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    check("resume_pc", bus.pc, 32'h0);
    check("resume_halted", {31'd0, bus.halted}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("resume_cap", 32'd0, 32'd4, 1'b1);
    check("resume_count", bus.fetch_count, 32'd8);

    // wrap at top of address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc0", bus.pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("wrap_pc", bus.pc, 32'h0);
    check_ifid("wrap", 32'd1533, 32'h0, 1'b1);

    // async reset between edges during a stall
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h0);
    check_ifid("arst", 32'h0, 32'h0, 1'b0);
    check("arst_count", bus.fetch_count, 32'h0);
    check("arst_halted", {31'd0, bus.halted}, 32'h0);
    check("arst_state", {30'd0, dut.state_q}, {30'd0, ST_BOOT});
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    halt_en = 1'b0;
    #1;
    rst_n_i = 1'b1;
    tick();
    check("arst_boot_valid", {31'd0, bus.ifid_valid}, 32'd0);
    tick();
    check_ifid("arst_run", 32'd0, 32'd4, 1'b1);

    // flush without stall advances PC and leaves a bubble
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("flush_pc", bus.pc, 32'h8);
    check("flush_valid", {31'd0, bus.ifid_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("post_flush", 32'd6, 32'hC, 1'b1);
    check("post_flush_count", bus.fetch_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
